token_sink: RTL

TOKEN_SINK -- requirements
Module: token_sink

---
 rtl/token_sink.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/token_sink.sv
// Token sink: synchronises an asynchronous Send_in request, acknowledges it
// with a fixed-length active-low Ack_out pulse, counts completed handshakes
// in two-digit BCD and multiplexes the count onto a 2-digit 7-segment display.
module token_sink #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_HOLD    = 4,
  parameter int unsigned SCAN_DIV    = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Send_in,
  input  logic       CLR,
  output logic       Ack_out,
  output logic [7:0] TOKEN_CNT,
  output logic       OVF,
  output logic [7:0] nHEX,
  output logic [1:0] nDIG
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_s_c;
  logic                   req_c;

  state_t                 state_q, state_next_c;
  logic [HOLD_W-1:0]      hold_q, hold_next_c;
  logic                   inc_c;

  logic [7:0]             cnt_next_c;
  logic                   ovf_next_c;

  logic [SCAN_W-1:0]      scan_q, scan_next_c;
  logic [1:0]             dig_next_c;
  logic                   tens_act_c;
  logic [3:0]             digit_c;
  logic [7:0]             hex_next_c;

  // Active-low 7-segment decode, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign sync_s_c = sync_q[SYNC_STAGES-1];
  assign req_c    = prev_q & ~sync_s_c;

  // Synchroniser chain and edge history; both idle high so a level held low
  // through reset is seen as a fresh request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Send_in};
      prev_q <= sync_s_c;
    end
  end

  // Handshake next-state: count on IDLE->ACK, hold ACK, wait for release.
  always_comb begin
    state_next_c = state_q;
    hold_next_c  = hold_q;
    inc_c        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_next_c = ACK;
          hold_next_c  = '0;
          inc_c        = 1'b1;
        end
      end
      ACK: begin
        if (hold_q == HOLD_W'(ACK_HOLD - 1)) begin
          state_next_c = WAIT_REL;
        end else begin
          hold_next_c = hold_q + HOLD_W'(1);
        end
      end
      WAIT_REL: begin
        if (sync_s_c) begin
          state_next_c = IDLE;
        end
      end
      default: state_next_c = IDLE;
    endcase
  end

  // BCD count and sticky overflow; a simultaneous clear and count yields 01.
  always_comb begin
    cnt_next_c = TOKEN_CNT;
    ovf_next_c = OVF;
    if (CLR) begin
      cnt_next_c = 8'h00;
      ovf_next_c = 1'b0;
    end
    if (inc_c) begin
      if (CLR) begin
        cnt_next_c = 8'h01;
      end else if (TOKEN_CNT[3:0] == 4'd9) begin
        if (TOKEN_CNT[7:4] == 4'd9) begin
          cnt_next_c = 8'h00;
          ovf_next_c = 1'b1;
        end else begin
          cnt_next_c = {TOKEN_CNT[7:4] + 4'd1, 4'd0};
        end
      end else begin
        cnt_next_c = {TOKEN_CNT[7:4], TOKEN_CNT[3:0] + 4'd1};
      end
    end
  end

  // Display scan; segments are decoded from next-cycle values so nHEX always
  // matches the nDIG and TOKEN_CNT it is registered alongside.
  always_comb begin
    scan_next_c = scan_q + SCAN_W'(1);
    dig_next_c  = nDIG;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_next_c = '0;
      dig_next_c  = ~nDIG;
    end
    tens_act_c = ~dig_next_c[1];
    digit_c    = tens_act_c ? cnt_next_c[7:4] : cnt_next_c[3:0];
    hex_next_c = {~(tens_act_c & ovf_next_c), seg_decode(digit_c)};
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      Ack_out   <= 1'b1;
      TOKEN_CNT <= 8'h00;
      OVF       <= 1'b0;
      scan_q    <= '0;
      nDIG      <= 2'b10;
      nHEX      <= 8'hC0;
    end else begin
      state_q   <= state_next_c;
      hold_q    <= hold_next_c;
      Ack_out   <= (state_next_c != ACK);
      TOKEN_CNT <= cnt_next_c;
      OVF       <= ovf_next_c;
      scan_q    <= scan_next_c;
      nDIG      <= dig_next_c;
      nHEX      <= hex_next_c;
    end
  end

endmodule
